// File: rtl/csel_pkg.sv
// Shared sizing and record types for the carry-select adder slice.
package csel_pkg;
   localparam int WIDTH_DEF = 16;
   localparam int BLK_DEF   = 4;

   function automatic int nblk(input int width, input int blk);
      return width / blk;
   endfunction

   // Per-block precompute record at the default block size; the adder
   // declares a BLK-sized twin so non-default configurations still build.
   typedef struct packed {
      logic [BLK_DEF-1:0] sum0;
      logic [BLK_DEF-1:0] sum1;
      logic               c0;
      logic               c1;
   } blk_rec_t;
endpackage

// File: rtl/csel_block.sv
// One carry-select block: sums and carry-outs for both possible carry-ins.
module csel_block import csel_pkg::*; #(
   parameter int BLK = BLK_DEF
) (
   input  logic [BLK-1:0] a,
   input  logic [BLK-1:0] b,
   output logic [BLK-1:0] sum0,
   output logic [BLK-1:0] sum1,
   output logic           c0,
   output logic           c1
);
   always_comb begin
      {c0, sum0} = {1'b0, a} + {1'b0, b};
      {c1, sum1} = {1'b0, a} + {1'b0, b} + (BLK+1)'(1);
   end
endmodule

// File: rtl/csel_adder_pipe.sv
// Two-stage pipelined carry-select adder with valid/ready on both sides.
// Define CSEL_OVF_EN to add the registered signed-overflow output OVF.
module csel_adder_pipe import csel_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF,
   parameter int BLK   = BLK_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] SUM,
   output logic             COUT
`ifdef CSEL_OVF_EN
   ,output logic            OVF
`endif
);
   localparam int NB = nblk(WIDTH, BLK);

   typedef struct packed {
      logic [BLK-1:0] sum0;
      logic [BLK-1:0] sum1;
      logic           c0;
      logic           c1;
   } rec_t;

   rec_t [NB-1:0]    pre_d, pre_q;
   logic             s1_valid, s1_cin, s2_valid;
   logic             s1_adv, s2_adv, in_fire;
   logic [NB:0]      carry;
   logic [WIDTH-1:0] sum_d;

   // Advance signals depend only on registered state and out_ready.
   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign in_ready  = s1_adv;
   assign in_fire   = in_valid && s1_adv;
   assign out_valid = s2_valid;

   for (genvar g = 0; g < NB; g++) begin : g_blk
      csel_block #(.BLK(BLK)) u_blk (
         .a    (A[g*BLK +: BLK]),
         .b    (B[g*BLK +: BLK]),
         .sum0 (pre_d[g].sum0),
         .sum1 (pre_d[g].sum1),
         .c0   (pre_d[g].c0),
         .c1   (pre_d[g].c1)
      );
   end

   always_ff @(posedge clk) begin
      if (rst)         s1_valid <= 1'b0;
      else if (s1_adv) s1_valid <= in_valid;
   end

   always_ff @(posedge clk) begin
      if (in_fire) begin
         pre_q  <= pre_d;
         s1_cin <= CIN;
      end
   end

   always_comb begin
      carry    = '0;
      sum_d    = '0;
      carry[0] = s1_cin;
      for (int i = 0; i < NB; i++) begin
         sum_d[i*BLK +: BLK] = carry[i] ? pre_q[i].sum1 : pre_q[i].sum0;
         carry[i+1]          = carry[i] ? pre_q[i].c1   : pre_q[i].c0;
      end
   end

   // SUM/COUT only load when a real result moves in, so a stall holds them.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         SUM      <= '0;
         COUT     <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            SUM  <= sum_d;
            COUT <= carry[NB];
         end
      end
   end

`ifdef CSEL_OVF_EN
   logic s1_amsb, s1_bmsb;

   always_ff @(posedge clk) begin
      if (in_fire) begin
         s1_amsb <= A[WIDTH-1];
         s1_bmsb <= B[WIDTH-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         OVF <= 1'b0;
      else if (s2_adv && s1_valid)
         OVF <= (s1_amsb == s1_bmsb) && (sum_d[WIDTH-1] != s1_amsb);
   end
`endif
endmodule

// File: tb/tb_csel_adder_pipe.sv
// Self-checking bench for csel_adder_pipe against an arithmetic reference.
module tb_csel_adder_pipe;
   localparam int W = 16;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
   } txn_t;

   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, CIN, out_valid, out_ready, COUT;
   logic [W-1:0] A, B, SUM;
`ifdef CSEL_OVF_EN
   logic         OVF;
`endif
   int errors = 0;
   int checks = 0;

   logic [W-1:0] dir_a   [3] = '{16'h00FF, 16'hFFFF, 16'h1234};
   logic [W-1:0] dir_b   [3] = '{16'h0001, 16'h0001, 16'h4321};
   logic         dir_c   [3] = '{1'b0, 1'b0, 1'b1};
   logic [W-1:0] dir_s   [3] = '{16'h0100, 16'h0000, 16'h5556};
   logic         dir_co  [3] = '{1'b0, 1'b1, 1'b0};
   logic [W-1:0] bp_exp  [3] = '{16'h0002, 16'h0004, 16'h0006};

   always #5 clk = ~clk;

   csel_adder_pipe #(.WIDTH(W), .BLK(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .CIN       (CIN),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .SUM       (SUM),
      .COUT      (COUT)
`ifdef CSEL_OVF_EN
      ,.OVF      (OVF)
`endif
   );

   // {ovf, cout, sum} from plain integer addition and the signed-overflow rule
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin);
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      return {(a[W-1] == b[W-1]) && (s[W-1] != a[W-1]), s};
   endfunction

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; CIN = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (SUM !== '0) begin errors++; $display("FAIL reset_sum: got %h want 0000", SUM); end
      checks++; if (COUT !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", COUT); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_directed();
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         A = dir_a[k]; B = dir_b[k]; CIN = dir_c[k]; in_valid = 1'b1; out_ready = 1'b1;
         @(negedge clk);
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL directed_in_ready[%0d]: got %b want 1", k, in_ready); end
         @(posedge clk); #1 in_valid = 1'b0;
         @(negedge clk);
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL directed_early[%0d]: out_valid got %b want 0", k, out_valid); end
         @(posedge clk); @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || SUM !== dir_s[k] || COUT !== dir_co[k]) begin
            errors++;
            $display("FAIL directed[%0d]: got v=%b sum=%h cout=%b want v=1 sum=%h cout=%b",
                     k, out_valid, SUM, COUT, dir_s[k], dir_co[k]);
         end
      end
   endtask

`ifdef CSEL_OVF_EN
   task automatic test_ovf();
      logic [W-1:0] oa [2] = '{16'h7FFF, 16'hFFFF};
      logic [W-1:0] ob [2] = '{16'h0000, 16'h0001};
      logic         oc [2] = '{1'b1, 1'b0};
      logic [W-1:0] os [2] = '{16'h8000, 16'h0000};
      logic         ov [2] = '{1'b1, 1'b0};
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         A = oa[k]; B = ob[k]; CIN = oc[k]; in_valid = 1'b1; out_ready = 1'b1;
         @(posedge clk); #1 in_valid = 1'b0;
         @(posedge clk); @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || SUM !== os[k] || OVF !== ov[k]) begin
            errors++;
            $display("FAIL ovf[%0d]: got v=%b sum=%h ovf=%b want v=1 sum=%h ovf=%b",
                     k, out_valid, SUM, OVF, os[k], ov[k]);
         end
      end
   endtask
`endif

   task automatic test_back_to_back();
      txn_t       q[$];
      txn_t       t;
      logic [W+1:0] m;
      int         got = 0;
      int         last = -1;
      localparam int N = 8;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < N + 6; cyc++) begin
         @(posedge clk); #1;
         if (cyc < N) begin
            A = W'($urandom); B = W'($urandom); CIN = 1'($urandom_range(0, 1)); in_valid = 1'b1;
         end else in_valid = 1'b0;
         @(negedge clk);
         if (out_valid) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL b2b_spurious: out_valid with nothing in flight at cycle %0d", cyc);
            end else begin
               t = q.pop_front();
               m = model(t.a, t.b, t.cin);
               if (SUM !== m[W-1:0] || COUT !== m[W]) begin
                  errors++; $display("FAIL b2b_data[%0d]: got sum=%h cout=%b want sum=%h cout=%b", got, SUM, COUT, m[W-1:0], m[W]);
               end
            end
            checks++;
            if ((last < 0 && cyc != 2) || (last >= 0 && cyc != last + 1)) begin
               errors++; $display("FAIL b2b_timing: result %0d at cycle %0d, previous at %0d", got, cyc, last);
            end
            last = cyc; got++;
         end
         if (in_valid) begin
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b want 1 at cycle %0d", in_ready, cyc); end
            else q.push_back('{a: A, b: B, cin: CIN});
         end
      end
      checks++; if (got != N) begin errors++; $display("FAIL b2b_count: got %0d results want %0d", got, N); end
   endtask

   task automatic test_backpressure();
      int  idx = 0;
      logic fired;
      out_ready = 1'b0;
      @(posedge clk); #1 A = 16'd1; B = 16'd1; CIN = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept1: in_ready got %b want 1", in_ready); end
      @(posedge clk); #1 A = 16'd2; B = 16'd2;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept2: in_ready got %b want 1", in_ready); end
      @(posedge clk); #1 A = 16'd3; B = 16'd3;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full[%0d]: in_ready got %b want 0", k, in_ready); end
         checks++;
         if (out_valid !== 1'b1 || SUM !== 16'h0002 || COUT !== 1'b0) begin
            errors++; $display("FAIL bp_hold[%0d]: got v=%b sum=%h cout=%b want v=1 sum=0002 cout=0", k, out_valid, SUM, COUT);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 10 && idx < 3; cyc++) begin
         @(negedge clk);
         fired = in_valid && in_ready;
         if (out_valid) begin
            checks++;
            if (SUM !== bp_exp[idx]) begin errors++; $display("FAIL bp_order[%0d]: got %h want %h", idx, SUM, bp_exp[idx]); end
            idx++;
         end
         @(posedge clk); #1;
         if (fired) in_valid = 1'b0;
      end
      checks++; if (idx != 3) begin errors++; $display("FAIL bp_count: got %0d results want 3", idx); end
   endtask

   task automatic test_mid_reset();
      int seen = 0;
      out_ready = 1'b0;
      @(posedge clk); #1 A = 16'd5; B = 16'd5; CIN = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1 A = 16'd6; B = 16'd6;
      @(posedge clk); #1 in_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         errors++; $display("FAIL rst_precond: in_ready=%b out_valid=%b want 0 and 1", in_ready, out_valid);
      end
      @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || SUM !== '0 || COUT !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL rst_mid: got v=%b sum=%h cout=%b rdy=%b want v=0 sum=0000 cout=0 rdy=1", out_valid, SUM, COUT, in_ready);
      end
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL rst_stale: got %0d stale outputs want 0", seen); end
   endtask

   task automatic test_random();
      txn_t         q[$];
      txn_t         t;
      logic [W+1:0] m;
      logic         stall_prev = 1'b0, fired_prev = 1'b1, cout_prev = 1'b0, exp_rdy;
      logic [W-1:0] sum_prev = '0;
      in_valid = 1'b0;
      for (int cyc = 0; cyc < 420; cyc++) begin
         @(posedge clk); #1;
         if (cyc >= 400) begin
            in_valid = 1'b0; out_ready = 1'b1;
         end else begin
            if (!in_valid || fired_prev) begin
               A = W'($urandom); B = W'($urandom); CIN = 1'($urandom_range(0, 1));
               in_valid = ($urandom_range(0, 9) < 7);
            end
            out_ready = ($urandom_range(0, 9) < 6);
         end
         @(negedge clk);
         exp_rdy = (q.size() < 2) || out_ready;
         checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_in_ready: got %b want %b at cycle %0d", in_ready, exp_rdy, cyc); end
         if (stall_prev) begin
            checks++;
            if (out_valid !== 1'b1 || SUM !== sum_prev || COUT !== cout_prev) begin
               errors++; $display("FAIL rnd_stall: got v=%b sum=%h cout=%b want v=1 sum=%h cout=%b", out_valid, SUM, COUT, sum_prev, cout_prev);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL rnd_spurious: output with nothing in flight at cycle %0d", cyc);
            end else begin
               t = q.pop_front();
               m = model(t.a, t.b, t.cin);
               if (SUM !== m[W-1:0] || COUT !== m[W]) begin
                  errors++; $display("FAIL rnd_data: a=%h b=%h cin=%b got sum=%h cout=%b want sum=%h cout=%b",
                                     t.a, t.b, t.cin, SUM, COUT, m[W-1:0], m[W]);
               end
`ifdef CSEL_OVF_EN
               if (OVF !== m[W+1]) begin
                  errors++; $display("FAIL rnd_ovf: a=%h b=%h cin=%b got %b want %b", t.a, t.b, t.cin, OVF, m[W+1]);
               end
`endif
            end
         end
         fired_prev = in_valid && in_ready;
         if (fired_prev) q.push_back('{a: A, b: B, cin: CIN});
         stall_prev = out_valid && !out_ready;
         sum_prev   = SUM;
         cout_prev  = COUT;
      end
      checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_drain: %0d results never emitted", q.size()); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_directed();
`ifdef CSEL_OVF_EN
      test_ovf();
`endif
      test_back_to_back();
      test_backpressure();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/csel_adder_pipe.md
Name: csel_adder_pipe

Overview:
- Two-stage pipelined carry-select adder with a valid/ready handshake on both sides.
- Stage 1 splits the operands into BLK-bit blocks. Each block precomputes a sum and carry-out for carry-in 0 and for carry-in 1. These results feed the 2:1 multiplexer selection stage.
- Stage 2 resolves the block carry chain through 2:1 selects and registers the final sum.
- Used as the registered adder datapath for the carry-select experiments. It replaces the purely combinational adder in timing-closed designs.

Parameters:
- WIDTH, 16, operand and sum width; must be a multiple of BLK.
- BLK, 4, bits per carry-select block; NBLK = WIDTH/BLK.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands A, B, CIN are valid
- in_ready  out  1  block accepts operands this cycle
- A  in  WIDTH  operand A (unsigned bits; signed interpretation only for OVF)
- B  in  WIDTH  operand B
- CIN  in  1  carry into block 0
- out_valid  out  1  SUM/COUT valid
- out_ready  in  1  downstream accepts result
- SUM  out  WIDTH  A+B+CIN, low WIDTH bits
- COUT  out  1  carry out of MSB block
- OVF  out  1  signed overflow (present only with CSEL_OVF_EN)

Behaviour:
- Reset: on a rising clk with rst=1, s1_valid, s2_valid, out_valid, SUM, COUT and OVF all become 0. in_ready reads 1 the cycle after reset. Reset mid-operation discards every in-flight transaction; nothing is emitted afterwards.
- Transfer: a transfer occurs on a rising clk when valid && ready on that interface.
- Stage-1 registers, per block i:
  - sum0[i] and c0[i] = A_blk + B_blk + 0
  - sum1[i] and c1[i] = A_blk + B_blk + 1
  - registered CIN
  - Each computation is BLK+1 bits wide; the carry is the top bit.
- Stage 2 (combinational from s1 registers, registered into SUM/COUT):
  - carry[0] = CIN
  - SUM_blk[i] = carry[i] ? sum1[i] : sum0[i]
  - carry[i+1] = carry[i] ? c1[i] : c0[i]
  - COUT = carry[NBLK]
- Latency: exactly 2 cycles from input transfer to out_valid when out_ready is held at 1.
- Throughput: 1 result per cycle.
- Flow control:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv, a combinational function of registered state and out_ready; no path from in_valid.
  - A stage holds its contents whenever its advance signal is 0.
  - SUM/COUT must stay stable while out_valid=1 and out_ready=0.
- Simultaneous events:
  - With both stages full and out_ready=1, the pipeline shifts and accepts new input in the same cycle.
  - With out_ready=0 and both stages full, in_ready=0.
- Wrap-around: SUM is modulo 2^WIDTH; the carry is reported only on COUT.
- X on CIN or the select path is not masked; it propagates to SUM/COUT unchanged.

Optional Feature:
- Macro: CSEL_OVF_EN.
- Defined:
  - OVF port exists.
  - OVF = (A[MSB]==B[MSB]) && (SUM[MSB]!=A[MSB]), computed from stage-1 registered MSBs.
  - OVF is registered alongside SUM, with the same latency, stall and reset behaviour.
- Undefined: the OVF port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package csel_pkg holds:
  - default WIDTH and BLK localparams
  - function nblk(WIDTH, BLK)
  - a struct/typedef for the per-block precompute record {sum0, sum1, c0, c1}
- Sub-module csel_block:
  - BLK-bit dual ripple adder producing sum0, c0, sum1 and c1.
  - Instantiated NBLK times in stage 1 via generate.
- Stage-2 select chain: inline 2:1 selects, no sub-module.

Test Plan:
- A=0x00FF, B=0x0001, CIN=0, out_ready=1 -> 2 cycles later out_valid=1, SUM=0x0100, COUT=0.
- A=0xFFFF, B=0x0001, CIN=0 (carry ripples through all 4 blocks) -> SUM=0x0000, COUT=1.
- A=0x1234, B=0x4321, CIN=1 -> SUM=0x5556, COUT=0. Follow with back-to-back inputs every cycle -> one result per cycle, in order.
- Backpressure: out_ready=0, present 3 transactions (1+1, 2+2, 3+3) -> first 2 accepted, in_ready=0 on the third. SUM holds 0x0002 stable. After out_ready=1, results appear as 0x0002, 0x0004, 0x0006.
- rst=1 for 1 cycle with both stages full -> next cycle out_valid=0, SUM=0, COUT=0, in_ready=1; no stale result ever emitted.
- CSEL_OVF_EN defined:
  - A=0x7FFF, B=0x0000, CIN=1 -> SUM=0x8000, OVF=1.
  - A=0xFFFF, B=0x0001 -> OVF=0.
